// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Operand/result handshake bundle for the bit-serial subtractor.
//   start_valid / start_ready / a / b   : operand channel (master -> slave)
//   res_valid / res_ready / diff /
//   borrow / overflow                    : result channel (slave -> master)
// master modport: the operand producer / result consumer.
// slave modport : the subtractor itself.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start_valid, a, b, res_ready,
        input  start_ready, res_valid, diff, borrow, overflow
    );

    modport slave (
        input  start_valid, a, b, res_ready,
        output start_ready, res_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, with a single full-subtractor cell and a registered borrow.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_subtractor_if.slave (operand and result handshakes)
// Latency: accept at edge E0, result valid in the cycle after edge E0+WIDTH.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_sh_reg, res_sh_next;
    logic             borrow_r_reg, borrow_r_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_out_reg, borrow_out_next;
    logic             overflow_reg, overflow_next;

    // Full-subtractor cell on the current LSBs.
    logic             a0, b0, d_bit, borrow_cell;
    logic [WIDTH-1:0] res_shifted;

    assign a0          = a_sh_reg[0];
    assign b0          = b_sh_reg[0];
    assign d_bit       = a0 ^ b0 ^ borrow_r_reg;
    assign borrow_cell = (~a0 & b0) | (~a0 & borrow_r_reg) | (b0 & borrow_r_reg);
    // Result bits enter at the MSB so that after WIDTH steps bit 0 sits at the LSB.
    assign res_shifted = {d_bit, res_sh_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            res_sh_reg     <= '0;
            borrow_r_reg   <= 1'b0;
            cnt_reg        <= '0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            a_sh_reg       <= a_sh_next;
            b_sh_reg       <= b_sh_next;
            res_sh_reg     <= res_sh_next;
            borrow_r_reg   <= borrow_r_next;
            cnt_reg        <= cnt_next;
            diff_reg       <= diff_next;
            borrow_out_reg <= borrow_out_next;
            overflow_reg   <= overflow_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        a_sh_next       = a_sh_reg;
        b_sh_next       = b_sh_reg;
        res_sh_next     = res_sh_reg;
        borrow_r_next   = borrow_r_reg;
        cnt_next        = cnt_reg;
        diff_next       = diff_reg;
        borrow_out_next = borrow_out_reg;
        overflow_next   = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sh_next     = bus.a;
                    b_sh_next     = bus.b;
                    borrow_r_next = 1'b0;
                    cnt_next      = '0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_next     = {1'b0, a_sh_reg[WIDTH-1:1]};
                b_sh_next     = {1'b0, b_sh_reg[WIDTH-1:1]};
                res_sh_next   = res_shifted;
                borrow_r_next = borrow_cell;
                if (cnt_reg == LAST) begin
                    // borrow_r_reg is the borrow into the MSB here, so the
                    // signed overflow is carry-in XOR carry-out of the MSB.
                    diff_next       = res_shifted;
                    borrow_out_next = borrow_cell;
                    overflow_next   = borrow_r_reg ^ borrow_cell;
                    state_next      = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.start_ready = (state_reg == IDLE);
    assign bus.res_valid   = (state_reg == DONE);
    assign bus.diff        = diff_reg;
    assign bus.borrow      = borrow_out_reg;
    assign bus.overflow    = overflow_reg;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor for the ALU datapath. It computes A − B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. This is the subtract-direction counterpart of the ripple full-adder path. Operands enter and the result leaves through valid/ready handshakes, so the block can sit between the ALU operand register and the result mux with back-pressure.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal values are WIDTH ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start_valid  in  1  operands on a/b are valid.
- start_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- res_valid  out  1  diff/borrow/overflow hold a completed result.
- res_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  (a − b) mod 2^WIDTH.
- borrow  out  1  unsigned borrow out of the MSB, i.e. a < b unsigned.
- overflow  out  1  signed overflow of a − b.

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset state is IDLE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready:
    - load a and b into shift registers;
    - clear borrow_r and the bit counter;
    - go to SHIFT.
- SHIFT, one bit per cycle, taking a0/b0 from the LSBs of the shift registers:
  - d = a0 ^ b0 ^ borrow_r.
  - borrow_next = (~a0 & b0) | (~a0 & borrow_r) | (b0 & borrow_r).
  - d shifts into the MSB of the result shift register; the operand registers shift right.
  - On the MSB step (counter = WIDTH−1):
    - overflow_next = borrow_r ^ borrow_next, where borrow_r is the borrow into the MSB;
    - capture the result register, borrow_next and overflow_next into diff, borrow and overflow;
    - go to DONE.
- DONE:
  - res_valid = 1.
  - On res_ready, go to IDLE.
- diff, borrow and overflow change only on the capture edge into DONE. They hold their value until the next capture and are meaningful only while res_valid = 1.
- start_valid is ignored outside IDLE. a and b are sampled only on the accept edge and may change freely afterwards.
- The same-cycle DONE→accept path does not exist: after a result handshake, the next accept is possible one cycle later at the earliest.
- All arithmetic is modulo 2^WIDTH. No saturation. The bit counter is ⌈log2 WIDTH⌉ bits wide and does not wrap in normal operation.

## Timing
- Reset values (rst_n low, and the first cycle after release):
  - state = IDLE;
  - start_ready = 1;
  - res_valid = 0;
  - diff = 0, borrow = 0, overflow = 0;
  - internal registers = 0.
- Latency: operands accepted at edge E0 → SHIFT occupies edges E0+1 … E0+WIDTH → res_valid is high in the cycle after edge E0+WIDTH.
- start_ready goes low in the cycle after edge E0.
- Result handshake at edge E1 (res_valid & res_ready) → res_valid = 0 and start_ready = 1 in the cycle after E1.
- Minimum initiation interval: WIDTH + 2 cycles (with res_ready held high).
- Back-pressure: with res_ready low, the block stays in DONE indefinitely; res_valid, diff, borrow and overflow are held stable.
- Reset mid-operation, in SHIFT or DONE:
  - the operation is aborted immediately (asynchronously);
  - all outputs take their reset values;
  - the partial result is discarded and never presented.
- start_ready and res_valid are decoded from registered state only; there is no combinational path from any input to any output.

## Test plan
- WIDTH=8, a=0x35, b=0x12, res_ready=1 → after 8 cycles res_valid=1, diff=0x23, borrow=0, overflow=0.
- a=0x12, b=0x35 → diff=0xDD, borrow=1, overflow=0; a=0x00, b=0x00 → diff=0x00, borrow=0, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1; a=0x7F, b=0xFF → diff=0x80, borrow=1, overflow=1.
- Back-pressure: a=0xA0, b=0x0A with res_ready held low 5 cycles after res_valid → res_valid stays 1 and diff stays 0x96; start_valid pulses in that window are ignored. Then res_ready=1 → res_valid=0 next cycle and start_ready=1.
- Reset mid-op: accept a=0xFF, b=0x01, assert rst_n=0 at SHIFT cycle 4 → outputs immediately reset to 0 and state is IDLE. After release, a=0x10, b=0x01 → diff=0x0F, borrow=0, overflow=0.
- Random regression, 10k ops, WIDTH=8 and WIDTH=5, random start_valid/res_ready toggling: diff, borrow and overflow match the reference model a−b; exactly one result per accept; the latency rule holds for every op.
